uncache_bridge: RTL



---
 rtl/uncache_bridge_pkg.sv | 47 ++++
 rtl/uncache_bridge_if.sv | 83 ++++++++
 rtl/uncache_bridge_wr_chan.sv | 60 ++++++
 rtl/uncache_bridge.sv | 111 +++++++++++
 4 files changed

// File: rtl/uncache_bridge_pkg.sv
// Shared AXI encodings, default master IDs and the lane-strobe helper
// used by the uncached sram-like to AXI3 bridge.
package uncache_bridge_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  localparam logic [2:0] AXI_SIZE_1 = 3'd0;
  localparam logic [2:0] AXI_SIZE_2 = 3'd1;
  localparam logic [2:0] AXI_SIZE_4 = 3'd2;

  localparam logic [1:0] AXI_LOCK_NORMAL  = 2'b00;
  localparam logic [3:0] AXI_CACHE_DEVICE = 4'b0000;
  localparam logic [2:0] AXI_PROT_NONE    = 3'b000;

  // Default IDs per master; uncached users pick their own AXI_ID.
  localparam logic [3:0] AXI_ID_INST = 4'd0;
  localparam logic [3:0] AXI_ID_DATA = 4'd1;

  // Internal state made visible for checkers.
  typedef struct packed {
    logic [3:0] rd_cnt;
    logic       wr_busy;
    logic       aw_pend;
    logic       w_pend;
  } dbg_t;

  // sram-like size (3 behaves as word) to AXI AxSIZE.
  function automatic logic [2:0] size_to_axsize(input logic [1:0] size);
    logic [2:0] axsize;
    axsize = (size == 2'd3) ? AXI_SIZE_4 : {1'b0, size};
    return axsize;
  endfunction

  // Byte lanes touched by an access; wdata itself is never shifted.
  function automatic logic [3:0] size_to_strb(input logic [1:0] size,
                                              input logic [1:0] lo);
    logic [3:0] strb;
    case (size)
      2'd0:    strb = 4'b0001 << lo;
      2'd1:    strb = 4'b0011 << {lo[1], 1'b0};
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/uncache_bridge_if.sv
// sram-like request port and AXI3 port of the uncached bridge.
//
// Handshake rules for both interfaces: a transfer happens in a cycle where
// valid and ready are both high at the rising clock edge. Once valid is
// raised, the payload stays stable and valid stays high until that transfer.
// On the sram-like side req plays valid and addr_ok plays ready; data_ok is a
// single-cycle completion strobe with no back-pressure.

interface sram_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (output req, wr, size, addr, wdata,
                  input  rdata, addr_ok, data_ok);
  modport slave  (input  req, wr, size, addr, wdata,
                  output rdata, addr_ok, data_ok);
endinterface

interface axi3_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
                  input  arready,
                  input  rid, rdata, rresp, rlast, rvalid,
                  output rready,
                  output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
                  input  awready,
                  output wid, wdata, wstrb, wlast, wvalid,
                  input  wready,
                  input  bid, bresp, bvalid,
                  output bready);
  modport slave  (input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
                  output arready,
                  output rid, rdata, rresp, rlast, rvalid,
                  input  rready,
                  input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
                  output awready,
                  input  wid, wdata, wstrb, wlast, wvalid,
                  output wready,
                  output bid, bresp, bvalid,
                  input  bready);
endinterface

// File: rtl/uncache_bridge_wr_chan.sv
// Single outstanding write: registers the AW/W payload on accept, drives the
// two channels independently and completes on the B handshake.
module uncache_bridge_wr_chan
  import uncache_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        accept,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        awready,
  input  logic        wready,
  input  logic        bvalid,
  input  logic [3:0]  bid,
  output logic        wr_busy,
  output logic        aw_pend,
  output logic        w_pend,
  output logic        bready,
  output logic        b_done,
  output logic [31:0] awaddr,
  output logic [31:0] wdata_q,
  output logic [3:0]  wstrb,
  output logic [2:0]  awsize
);

  // The response is only taken once both request channels have gone out.
  assign bready = wr_busy & ~aw_pend & ~w_pend;
  assign b_done = bready & bvalid & (bid == AXI_ID);

  // Write progress flags; accept only happens while idle, so it never races a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_busy <= 1'b0;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
    end else if (accept) begin
      wr_busy <= 1'b1;
      aw_pend <= 1'b1;
      w_pend  <= 1'b1;
    end else begin
      if (aw_pend && awready) aw_pend <= 1'b0;
      if (w_pend && wready)   w_pend  <= 1'b0;
      if (b_done)             wr_busy <= 1'b0;
    end
  end

  // Payload capture; contents only matter while the pending flags are set.
  always_ff @(posedge clk) begin
    if (accept) begin
      awaddr  <= addr;
      wdata_q <= wdata;
      wstrb   <= size_to_strb(size, addr[1:0]);
      awsize  <= size_to_axsize(size);
    end
  end

endmodule

// File: rtl/uncache_bridge.sv
// Uncached sram-like to AXI3 bridge: in-order reads with up to MAX_RD in
// flight, one write at a time, and no mixing of reads and writes in flight so
// that data_ok always comes back in request order.
module uncache_bridge
  import uncache_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd1,
  parameter int         MAX_RD = 2,
  parameter int         CNT_W  = $clog2(MAX_RD + 1)
) (
  input  logic   clk,
  input  logic   rst,
  sram_if.slave  cpu,
  axi3_if.master axi,
  output dbg_t   dbg
);

  localparam logic [CNT_W-1:0] RD_LIMIT = CNT_W'(MAX_RD);

  logic [CNT_W-1:0] rd_cnt;
  logic             rd_grant;
  logic             ar_hs;
  logic             r_done;
  logic             wr_accept;
  logic             wr_busy;
  logic             aw_pend;
  logic             w_pend;
  logic             bready;
  logic             b_done;
  logic [31:0]      awaddr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic [2:0]       awsize_q;
  logic             unused_resp;

  // Reads pass straight through to AR; writes wait until no read is in flight.
  assign rd_grant  = cpu.req & ~cpu.wr & ~wr_busy & (rd_cnt < RD_LIMIT);
  assign ar_hs     = rd_grant & axi.arready;
  assign r_done    = axi.rvalid & axi.rlast & (axi.rid == AXI_ID) & (rd_cnt != '0);
  assign wr_accept = cpu.req & cpu.wr & ~wr_busy & (rd_cnt == '0);

  assign cpu.addr_ok = ar_hs | wr_accept;
  assign cpu.data_ok = r_done | b_done;
  assign cpu.rdata   = axi.rdata;

  assign axi.arid    = AXI_ID;
  assign axi.araddr  = cpu.addr;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = size_to_axsize(cpu.size);
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arlock  = AXI_LOCK_NORMAL;
  assign axi.arcache = AXI_CACHE_DEVICE;
  assign axi.arprot  = AXI_PROT_NONE;
  assign axi.arvalid = rd_grant;
  assign axi.rready  = 1'b1;

  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = awaddr_q;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = awsize_q;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.awlock  = AXI_LOCK_NORMAL;
  assign axi.awcache = AXI_CACHE_DEVICE;
  assign axi.awprot  = AXI_PROT_NONE;
  assign axi.awvalid = aw_pend;
  assign axi.wid     = AXI_ID;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = w_pend;
  assign axi.bready  = bready;

  // Bus error responses are not reported in this generation.
  assign unused_resp = ^{axi.rresp, axi.bresp};

  assign dbg = '{rd_cnt: 4'(rd_cnt), wr_busy: wr_busy, aw_pend: aw_pend, w_pend: w_pend};

  // Outstanding-read count; an issue and a return in one cycle cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt <= '0;
    end else if (ar_hs && !r_done) begin
      rd_cnt <= rd_cnt + CNT_W'(1);
    end else if (r_done && !ar_hs) begin
      rd_cnt <= rd_cnt - CNT_W'(1);
    end
  end

  uncache_bridge_wr_chan #(.AXI_ID(AXI_ID)) u_wr_chan (
    .clk     (clk),
    .rst     (rst),
    .accept  (wr_accept),
    .size    (cpu.size),
    .addr    (cpu.addr),
    .wdata   (cpu.wdata),
    .awready (axi.awready),
    .wready  (axi.wready),
    .bvalid  (axi.bvalid),
    .bid     (axi.bid),
    .wr_busy (wr_busy),
    .aw_pend (aw_pend),
    .w_pend  (w_pend),
    .bready  (bready),
    .b_done  (b_done),
    .awaddr  (awaddr_q),
    .wdata_q (wdata_q),
    .wstrb   (wstrb_q),
    .awsize  (awsize_q)
  );

endmodule
